// File: rtl/n1_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the n1 sequencer.
package n1_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned ARG_HI = 7;
    localparam int unsigned ARG_LO = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StRead,
        StWrite,
        StExec,
        StHalt
    } state_e;

    // Opcodes 0xA-0xE are undefined.
    function automatic logic is_legal(input logic [3:0] opc);
        return (opc <= OP_OUT) || (opc == OP_HLT);
    endfunction

endpackage

// File: rtl/n1_seq_ctrl_if.sv
// Program RAM read port and data RAM read/write port seen by the sequencer.
interface n1_seq_ctrl_if #(
    parameter int unsigned AW = 8
);
    logic          pram_rd;
    logic [AW-1:0] pram_addr;
    logic [15:0]   pram_rdata;
    logic          dram_rd;
    logic          dram_wr;
    logic [AW-1:0] dram_addr;
    logic [7:0]    dram_wdata;
    logic [7:0]    dram_rdata;

    modport master (
        output pram_rd, pram_addr, dram_rd, dram_wr, dram_addr, dram_wdata,
        input  pram_rdata, dram_rdata
    );

    modport slave (
        input  pram_rd, pram_addr, dram_rd, dram_wr, dram_addr, dram_wdata,
        output pram_rdata, dram_rdata
    );
endinterface

// File: rtl/n1_alu.sv
// Combinational 8-bit datapath for the load and add/subtract opcodes.
module n1_alu
    import n1_pkg::*;
(
    input  logic [7:0] acc_i,
    input  logic [7:0] operand_i,
    input  logic [3:0] opc_i,
    output logic [7:0] res_o,
    output logic       z_o,
    output logic       c_o
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
    // Bit 8 of the widened difference is the borrow.
    assign diff = {1'b0, acc_i} - {1'b0, operand_i};

    always_comb begin
        res_o = acc_i;
        c_o   = 1'b0;
        case (opc_i)
            OP_LDI, OP_LDA: res_o = operand_i;
            OP_ADD:         {c_o, res_o} = sum;
            OP_SUB:         {c_o, res_o} = diff;
            default:        ;
        endcase
    end

    assign z_o = (res_o == 8'h00);

endmodule

// File: rtl/n1_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns PC, IR, ACC, Z/C flags and the output register.
module n1_seq_ctrl
    import n1_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          stop_req_i,
    n1_seq_ctrl_if.master bus,
    output logic [7:0]    out_data_o,
    output logic          out_valid_o,
    output logic          busy_o,
    output logic          halted_o,
    output logic          illegal_o,
    output logic [AW-1:0] pc_dbg_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [7:0]    acc_q, acc_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          illegal_q, illegal_d;

    logic          pram_rd, dram_rd, dram_wr;
    logic [3:0]    opc, dec_opc;
    logic [7:0]    arg;
    logic [AW-1:0] arg_addr;
    logic [7:0]    alu_b, alu_res;
    logic          alu_z, alu_c;
    logic          unused_rsvd;

    assign opc         = ir_q[OPC_HI:OPC_LO];
    assign arg         = ir_q[ARG_HI:ARG_LO];
    assign arg_addr    = AW'(arg);
    assign dec_opc     = bus.pram_rdata[OPC_HI:OPC_LO];
    assign unused_rsvd = ^ir_q[11:8];
    assign alu_b       = (opc == OP_LDI) ? arg : bus.dram_rdata;

    n1_alu u_alu (
        .acc_i    (acc_q),
        .operand_i(alu_b),
        .opc_i    (opc),
        .res_o    (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        illegal_d   = illegal_q;
        pram_rd     = 1'b0;
        dram_rd     = 1'b0;
        dram_wr     = 1'b0;
        unique case (state_q)
            StIdle: if (start_i) state_d = StFetch;
            StFetch: begin
                if (stop_req_i) begin
                    state_d = StIdle;
                end else begin
                    pram_rd = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ir_d = bus.pram_rdata;
                pc_d = pc_q + AW'(1);
                case (dec_opc)
                    OP_LDA, OP_ADD, OP_SUB: state_d = StRead;
                    OP_STA:                 state_d = StWrite;
                    OP_HLT:                 state_d = StHalt;
                    default: begin
                        if (!is_legal(dec_opc)) begin
                            state_d   = StHalt;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = StExec;
                        end
                    end
                endcase
            end
            StRead: begin
                dram_rd = 1'b1;
                state_d = StExec;
            end
            StWrite: begin
                dram_wr = 1'b1;
                state_d = StFetch;
            end
            StExec: begin
                state_d = StFetch;
                case (opc)
                    OP_LDI, OP_LDA: begin
                        acc_d = alu_res;
                        z_d   = alu_z;
                    end
                    OP_ADD, OP_SUB: begin
                        acc_d = alu_res;
                        z_d   = alu_z;
                        c_d   = alu_c;
                    end
                    OP_JMP: pc_d = arg_addr;
                    OP_JZ:  if (z_q) pc_d = arg_addr;
                    OP_JC:  if (c_q) pc_d = arg_addr;
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            StHalt: begin
                if (start_i) begin
                    illegal_d = 1'b0;
                    state_d   = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    // Strobes are masked while rst is high so a mid-instruction reset issues no access.
    assign bus.pram_rd    = pram_rd & ~rst;
    assign bus.dram_rd    = dram_rd & ~rst;
    assign bus.dram_wr    = dram_wr & ~rst;
    assign bus.pram_addr  = pc_q;
    assign bus.dram_addr  = arg_addr;
    assign bus.dram_wdata = acc_q;

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != StIdle) && (state_q != StHalt);
    assign halted_o    = (state_q == StHalt);
    assign illegal_o   = illegal_q;
    assign pc_dbg_o    = pc_q;

endmodule

// File: tb/tb_n1_seq_ctrl.sv
// Directed bench for n1_seq_ctrl with behavioural program/data RAMs.
module tb_n1_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop_req = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, busy, halted, illegal;
    logic [7:0] pc_dbg;

    n1_seq_ctrl_if #(.AW(8)) bus ();

    n1_seq_ctrl #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .stop_req_i (stop_req),
        .bus        (bus),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .busy_o     (busy),
        .halted_o   (halted),
        .illegal_o  (illegal),
        .pc_dbg_o   (pc_dbg)
    );

    always #5 clk = ~clk;

    logic [15:0] pram     [256];
    logic [7:0]  ram_init [256];
    logic [7:0]  wr_mem   [256];
    logic        wr_valid [256];
    logic        mem_clr = 1'b0;

    always @(posedge clk) begin
        if (bus.pram_rd) bus.pram_rdata <= pram[bus.pram_addr];
        if (bus.dram_rd)
            bus.dram_rdata <= wr_valid[bus.dram_addr] ? wr_mem[bus.dram_addr]
                                                      : ram_init[bus.dram_addr];
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
        end else if (bus.dram_wr) begin
            wr_mem[bus.dram_addr]   <= bus.dram_wdata;
            wr_valid[bus.dram_addr] <= 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;
    int edges, ov_cnt, wr_cnt, overlap_total = 0;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] pc_tr [64];
    logic       prd_tr [64];
    logic [7:0] paddr_tr [64];

    task automatic do_reset();
        rst = 1'b1; mem_clr = 1'b1; start = 1'b0; stop_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pram[i] = 16'h0000;
            ram_init[i] = 8'h00;
        end
    endtask

    // Caller raises start at a negedge; index k is the state after the k-th edge past start.
    task automatic run_cycles(input int n, input bit stop_on_halt);
        ov_cnt = 0; wr_cnt = 0; edges = -1; wr_addr = 8'h00; wr_data = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            edges = k;
            if (k < 64) begin
                pc_tr[k] = pc_dbg; prd_tr[k] = bus.pram_rd; paddr_tr[k] = bus.pram_addr;
            end
            if (out_valid) ov_cnt++;
            if (bus.dram_wr) begin wr_cnt++; wr_addr = bus.dram_addr; wr_data = bus.dram_wdata; end
            if (bus.pram_rd && (bus.dram_rd || bus.dram_wr)) overlap_total++;
            if (stop_on_halt && halted) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal: got %b expected 0", illegal); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        checks++; if (pc_dbg !== 8'h00) begin failures++; $display("FAIL rst_pc: got %h expected 00", pc_dbg); end
        checks++; if ({bus.pram_rd, bus.dram_rd, bus.dram_wr} !== 3'b000) begin
            failures++; $display("FAIL rst_strobes: got %b expected 000", {bus.pram_rd, bus.dram_rd, bus.dram_wr}); end
    endtask

    task automatic test_program();
        do_reset();
        pram[0] = 16'h2000; pram[1] = 16'h4001; pram[2] = 16'h9000; pram[3] = 16'hF000;
        ram_init[0] = 8'h01; ram_init[1] = 8'h02;
        start = 1'b1;
        run_cycles(40, 1'b1);
        checks++; if (halted !== 1'b1 || edges !== 13) begin
            failures++; $display("FAIL prog_halt_edge: got halted=%b edge=%0d expected 1 13", halted, edges); end
        checks++; if (out_data !== 8'h03) begin failures++; $display("FAIL prog_out_data: got %h expected 03", out_data); end
        checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL prog_out_pulses: got %0d expected 1", ov_cnt); end
        checks++; if (pc_dbg !== 8'h04) begin failures++; $display("FAIL prog_pc: got %h expected 04", pc_dbg); end
        checks++; if (prd_tr[0] !== 1'b1 || paddr_tr[0] !== 8'h00) begin
            failures++; $display("FAIL prog_first_fetch: got rd=%b addr=%h expected 1 00", prd_tr[0], paddr_tr[0]); end
    endtask

    task automatic test_arith_flags();
        do_reset();
        pram[0] = 16'h10FF; pram[1] = 16'h4005; pram[2] = 16'h9000; pram[3] = 16'h7010;
        pram[8'h10] = 16'h8020; pram[8'h20] = 16'hF000;
        ram_init[5] = 8'h01;
        start = 1'b1;
        run_cycles(40, 1'b1);
        checks++; if (ov_cnt !== 1 || out_data !== 8'h00) begin
            failures++; $display("FAIL arith_acc: got pulses=%0d acc=%h expected 1 00", ov_cnt, out_data); end
        checks++; if (pc_tr[13] !== 8'h10) begin failures++; $display("FAIL arith_jz_taken: got %h expected 10", pc_tr[13]); end
        checks++; if (pc_tr[16] !== 8'h20) begin failures++; $display("FAIL arith_jc_taken: got %h expected 20", pc_tr[16]); end
        checks++; if (halted !== 1'b1 || edges !== 18 || pc_dbg !== 8'h21) begin
            failures++; $display("FAIL arith_halt: got h=%b e=%0d pc=%h expected 1 18 21", halted, edges, pc_dbg); end
    endtask

    task automatic test_store_load();
        do_reset();
        pram[0] = 16'h1005; pram[1] = 16'h3020; pram[2] = 16'h1000; pram[3] = 16'h2020;
        pram[4] = 16'h9000; pram[5] = 16'h7040; pram[6] = 16'h8040; pram[7] = 16'hF000;
        pram[8'h40] = 16'hF000;
        start = 1'b1;
        run_cycles(60, 1'b1);
        checks++; if (wr_cnt !== 1 || wr_addr !== 8'h20 || wr_data !== 8'h05) begin
            failures++; $display("FAIL st_write: got n=%0d a=%h d=%h expected 1 20 05", wr_cnt, wr_addr, wr_data); end
        checks++; if (out_data !== 8'h05) begin failures++; $display("FAIL st_out_data: got %h expected 05", out_data); end
        checks++; if (halted !== 1'b1 || edges !== 24 || pc_dbg !== 8'h08) begin
            failures++; $display("FAIL st_no_jump: got h=%b e=%0d pc=%h expected 1 24 08", halted, edges, pc_dbg); end
    endtask

    task automatic test_illegal();
        do_reset();
        pram[3] = 16'hB000; pram[4] = 16'h105A; pram[5] = 16'h9000; pram[6] = 16'hF000;
        start = 1'b1;
        run_cycles(40, 1'b1);
        checks++; if (halted !== 1'b1 || illegal !== 1'b1 || pc_dbg !== 8'h04 || edges !== 11) begin
            failures++; $display("FAIL ill_halt: got h=%b i=%b pc=%h e=%0d expected 1 1 04 11",
                                 halted, illegal, pc_dbg, edges); end
        start = 1'b1;
        run_cycles(1, 1'b0);
        checks++; if (illegal !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL ill_clear: got i=%b busy=%b expected 0 1", illegal, busy); end
        run_cycles(40, 1'b1);
        checks++; if (halted !== 1'b1 || out_data !== 8'h5A || pc_dbg !== 8'h07) begin
            failures++; $display("FAIL ill_resume: got h=%b out=%h pc=%h expected 1 5a 07", halted, out_data, pc_dbg); end
    endtask

    task automatic test_wrap_stop();
        do_reset();
        pram[0] = 16'h60FF; pram[8'hFF] = 16'h0000;
        start = 1'b1;
        run_cycles(9, 1'b0);
        checks++; if (pc_tr[3] !== 8'hFF) begin failures++; $display("FAIL wrap_jmp: got %h expected ff", pc_tr[3]); end
        checks++; if (pc_tr[6] !== 8'h00 || prd_tr[6] !== 1'b1 || paddr_tr[6] !== 8'h00) begin
            failures++; $display("FAIL wrap_fetch0: got pc=%h rd=%b a=%h expected 00 1 00",
                                 pc_tr[6], prd_tr[6], paddr_tr[6]); end
        stop_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.pram_rd !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL stop_no_fetch: got rd=%b busy=%b expected 0 1", bus.pram_rd, busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || pc_dbg !== 8'hFF) begin
            failures++; $display("FAIL stop_idle: got b=%b h=%b pc=%h expected 0 0 ff", busy, halted, pc_dbg); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (bus.pram_rd !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL startstop_fetch: got rd=%b busy=%b expected 0 1", bus.pram_rd, busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || pc_dbg !== 8'hFF) begin
            failures++; $display("FAIL startstop_idle: got b=%b pc=%h expected 0 ff", busy, pc_dbg); end
        stop_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pram[0] = 16'h1033; pram[1] = 16'h4000;
        ram_init[0] = 8'h07;
        start = 1'b1;
        run_cycles(6, 1'b0);
        checks++; if (bus.dram_rd !== 1'b1) begin failures++; $display("FAIL mid_in_read: got %b expected 1", bus.dram_rd); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.pram_rd, bus.dram_rd, bus.dram_wr} !== 3'b000) begin
            failures++; $display("FAIL mid_rst_cycle: got %b expected 000", {bus.pram_rd, bus.dram_rd, bus.dram_wr}); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || pc_dbg !== 8'h00 || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_after: got b=%b h=%b pc=%h ov=%b expected 0 0 00 0",
                                 busy, halted, pc_dbg, out_valid); end
        @(negedge clk);
        checks++; if ({bus.pram_rd, bus.dram_rd, bus.dram_wr} !== 3'b000 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_next_cycle: got %b busy=%b expected 000 0",
                                 {bus.pram_rd, bus.dram_rd, bus.dram_wr}, busy); end
        pram[0] = 16'h3030; pram[1] = 16'hF000;
        start = 1'b1;
        run_cycles(20, 1'b1);
        checks++; if (halted !== 1'b1 || wr_cnt !== 1 || wr_addr !== 8'h30 || wr_data !== 8'h00) begin
            failures++; $display("FAIL mid_acc_cleared: got h=%b n=%0d a=%h d=%h expected 1 1 30 00",
                                 halted, wr_cnt, wr_addr, wr_data); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_arith_flags();
        test_store_load();
        test_illegal();
        test_wrap_stop();
        test_reset_mid();
        checks++; if (overlap_total !== 0) begin
            failures++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_total); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n1_seq_ctrl.md
Name: n1_seq_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer for the n1 core.
- Drives the program RAM read port and the data RAM read/write port, and owns PC, IR, accumulator and the Z/C flags.
- Produces the 8-bit output register that feeds uo_out.
- Sits between the top-level pin wrapper and the two RAMs. Both RAMs are external to this block and have synchronous read with 1-cycle latency.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset.
- AW, 8, width of the program and data address buses (PC wraps modulo 2^AW).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  in IDLE or HALT: begin or resume execution at the current PC
- stop_req  in  1  level; honoured at instruction boundary: return to IDLE
- pram_rd  out  1  program RAM read strobe
- pram_addr  out  AW  program RAM address (= PC)
- pram_rdata  in  16  instruction word, valid the cycle after pram_rd
- dram_rd  out  1  data RAM read strobe
- dram_wr  out  1  data RAM write strobe
- dram_addr  out  AW  data RAM address (= IR[7:0])
- dram_wdata  out  8  write data (= ACC)
- dram_rdata  in  8  read data, valid the cycle after dram_rd
- out_data  out  8  output register
- out_valid  out  1  1-cycle pulse when out_data is updated
- busy  out  1  high in FETCH, DECODE, READ, WRITE and EXEC
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when an undefined opcode is decoded
- pc_dbg  out  AW  current PC

Behaviour:
- Instruction format: [15:12] opcode, [11:8] reserved (ignored), [7:0] operand (address or immediate).
- Opcodes:
  - 0 NOP
  - 1 LDI: ACC=imm
  - 2 LDA: ACC=ram[a]
  - 3 STA: ram[a]=ACC
  - 4 ADD: {C,ACC}=ACC+ram[a]
  - 5 SUB: ACC=ACC-ram[a], C=borrow
  - 6 JMP: PC=a
  - 7 JZ: PC=a if Z
  - 8 JC: PC=a if C
  - 9 OUT: out_data=ACC, out_valid pulse
  - F HLT
  - A-E: illegal
- Z is updated by LDI, LDA, ADD and SUB (Z = (new ACC==0)). C is updated only by ADD and SUB. All arithmetic is 8-bit and wraps.
- State machine: IDLE, FETCH, DECODE, READ, WRITE, EXEC, HALT.
- IDLE:
  - start=1 -> FETCH.
  - All strobes are 0.
- FETCH:
  - pram_rd=1, pram_addr=PC.
  - If stop_req=1 on entry, go to IDLE instead; no strobe is issued and PC is unchanged.
- DECODE:
  - IR<=pram_rdata; PC<=PC+1 (255 wraps to 0).
  - Next state: LDA/ADD/SUB -> READ; STA -> WRITE; HLT -> HALT; illegal -> HALT with illegal<=1; all others -> EXEC.
- READ:
  - dram_rd=1, dram_addr=IR[7:0].
  - Next state: EXEC, which consumes dram_rdata.
- WRITE:
  - dram_wr=1, dram_wdata=ACC.
  - Next state: FETCH.
- EXEC:
  - Applies the opcode effect.
  - Jumps load PC with IR[7:0]. A taken jump overrides the DECODE increment.
  - Next state: FETCH.
- Instruction latencies: LDA/ADD/SUB 4 cycles; STA, NOP, LDI, jumps and OUT 3 cycles; HLT enters HALT after 2 cycles.
- HALT:
  - Strobes are 0.
  - start=1 clears illegal and goes to FETCH at the current PC (the instruction after HLT).
- Strobes are combinational from state and IR. pram_rd and dram_rd/dram_wr are never asserted in the same cycle.
- out_data holds its value until the next OUT. out_valid is registered and high only in the cycle after EXEC of OUT.
- Reset (any state, including mid-instruction):
  - State<=IDLE, PC<=RESET_PC.
  - IR, ACC, Z, C, out_data, out_valid, illegal<=0.
  - No strobe is asserted in the reset cycle or the cycle after.
- If start and stop_req are both high in IDLE, go to FETCH; the stop takes effect on FETCH entry, so the controller returns to IDLE without issuing a fetch.

Decomposition:
- Package n1_pkg:
  - opcode localparams (OP_NOP..OP_HLT);
  - state enum typedef;
  - instruction field slice constants (OPC_HI/LO, ARG_HI/LO).
- Sub-module n1_alu (combinational): ACC, operand and opcode in; result, Z and C out.
- FSM, PC, IR and registers stay in n1_seq_ctrl.

Test Plan:
- Setup: pram = 0x2000 (LDA 0), 0x4001 (ADD 1), 0x9000 (OUT), 0xF000 (HLT); ram[0]=1, ram[1]=2; pulse start.
  Required: out_data=0x03 with a single out_valid pulse; halted rises 13 edges after the start edge; PC=4.
- LDI 0xFF, then ADD of ram[x]=0x01.
  Required: ACC=0x00, Z=1, C=1. A following JZ 0x10 loads PC=0x10. JC is taken too.
- LDI 0x05, STA 0x20, LDI 0, LDA 0x20, OUT.
  Required: dram_wr pulse with addr 0x20 and wdata 0x05; out_data=0x05.
- Opcode 0xB000 at PC 3.
  Required: halted=1, illegal=1, PC=4. start then clears illegal and resumes at 4.
- JMP 0xFF with pram[0xFF]=NOP.
  Required: after the NOP, PC wraps to 0x00 and fetches pram[0].
- Assert rst during the READ of an ADD.
  Required: next cycle state is IDLE, no strobes, PC=RESET_PC, ACC=0, out_valid=0. stop_req held high during a run returns the controller to IDLE at the next FETCH with PC unchanged.
